// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through, sticky overrun flag.
// Define UART_RX_FIFO_DROP_CNT_EN to add the saturating drop_cnt output.
module uart_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  input  logic              ovr_clr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overrun
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              push, pop, drop;

  // Handshake: a byte leaves the FIFO on any cycle where rd_valid && rd_ready
  // at the rising edge; rd_data holds the head whenever rd_valid is high.
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign rd_valid    = !empty;
  assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign count       = count_q;
  assign overrun     = overrun_q;

  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovr_clr)                        drop_cnt_d = drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= 8'd0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus a randomized run against a queue model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_ready, ovr_clr;
  logic [7:0] wr_data;
  logic       rd_valid, full, empty, almost_full, overrun;
  logic [7:0] rd_data;
  logic [4:0] count;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  logic [7:0] exp_q[$];
  bit         m_ovr;
  int         m_drop;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_ready(rd_ready), .ovr_clr(ovr_clr), .rd_valid(rd_valid),
    .rd_data(rd_data), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .overrun(overrun)
`ifdef UART_RX_FIFO_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // One clock: model follows the FIFO rules for the inputs driven now.
  task automatic cycle();
    bit m_pop, m_full, m_push, m_dr;
    m_pop  = (exp_q.size() > 0) && rd_ready;
    m_full = (exp_q.size() == 16);
    m_push = wr_en && (!m_full || m_pop);
    m_dr   = wr_en && m_full && !m_pop;
    @(posedge clk);
    if (m_pop)  void'(exp_q.pop_front());
    if (m_push) exp_q.push_back(wr_data);
    if (m_dr) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    if (ovr_clr) m_drop = m_dr ? 1 : 0;
    else if (m_dr && m_drop < 255) m_drop++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    wr_en = 0; rd_ready = 0; ovr_clr = 0; wr_data = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); m_ovr = 0; m_drop = 0;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'(i);
      cycle();
    end
    wr_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 7;
    if (empty !== 1'b1)       begin n_fail++; $display("FAIL reset_empty: got %b exp 1", empty); end
    if (rd_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); end
    if (rd_data !== 8'h00)    begin n_fail++; $display("FAIL reset_rd_data: got %h exp 00", rd_data); end
    if (count !== 5'd0)       begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
    if (overrun !== 1'b0)     begin n_fail++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    if (full !== 1'b0)        begin n_fail++; $display("FAIL reset_full: got %b exp 0", full); end
    if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b exp 0", almost_full); end
  endtask

  task automatic test_single();
    do_reset();
    wr_en = 1; wr_data = 8'hA5;
    n_tests++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b exp 0", rd_valid); end
    cycle();
    wr_en = 0;
    n_tests += 3;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_rd_valid: got %b exp 1", rd_valid); end
    if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_rd_data: got %h exp a5", rd_data); end
    if (count !== 5'd1)    begin n_fail++; $display("FAIL single_count: got %0d exp 1", count); end
    rd_ready = 1;
    cycle();
    rd_ready = 0;
    n_tests += 2;
    if (empty !== 1'b1)    begin n_fail++; $display("FAIL single_empty: got %b exp 1", empty); end
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL single_rd_data_empty: got %h exp 00", rd_data); end
  endtask

  task automatic test_fill_order();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'(i);
      cycle();
      n_tests += 2;
      if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, count, i + 1); end
      if (almost_full !== (i + 1 >= 12)) begin
        n_fail++; $display("FAIL fill_almost_full[%0d]: got %b exp %b", i, almost_full, (i + 1 >= 12));
      end
    end
    wr_en = 0;
    n_tests++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b exp 1", full); end
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h exp %h", i, rd_data, 8'(i)); end
      cycle();
    end
    rd_ready = 0;
    n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b exp 1", empty); end
  endtask

  task automatic test_overrun();
    do_reset();
    fill_seq();
    wr_en = 1; wr_data = 8'h55;
    cycle();
    wr_en = 0;
    n_tests += 3;
    if (overrun !== 1'b1)  begin n_fail++; $display("FAIL ovr_set: got %b exp 1", overrun); end
    if (count !== 5'd16)   begin n_fail++; $display("FAIL ovr_count: got %0d exp 16", count); end
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL ovr_head: got %h exp 00", rd_data); end
`ifdef UART_RX_FIFO_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_drop_cnt: got %0d exp 1", drop_cnt); end
`endif
    ovr_clr = 1;
    cycle();
    ovr_clr = 0;
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
`ifdef UART_RX_FIFO_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ovr_drop_clear: got %0d exp 0", drop_cnt); end
`endif
    wr_en = 1; wr_data = 8'h66; ovr_clr = 1;
    cycle();
    wr_en = 0; ovr_clr = 0;
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b exp 1", overrun); end
`ifdef UART_RX_FIFO_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_drop_with_clr: got %0d exp 1", drop_cnt); end
`endif
    ovr_clr = 1;
    cycle();
    ovr_clr = 0;
  endtask

  task automatic test_full_simul();
    do_reset();
    fill_seq();
    wr_en = 1; wr_data = 8'h77; rd_ready = 1;
    cycle();
    wr_en = 0; rd_ready = 0;
    n_tests += 3;
    if (count !== 5'd16)   begin n_fail++; $display("FAIL simul_count: got %0d exp 16", count); end
    if (overrun !== 1'b0)  begin n_fail++; $display("FAIL simul_overrun: got %b exp 0", overrun); end
    if (rd_data !== 8'h01) begin n_fail++; $display("FAIL simul_head: got %h exp 01", rd_data); end
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (rd_data !== ((i < 15) ? 8'(i + 1) : 8'h77)) begin
        n_fail++; $display("FAIL simul_drain[%0d]: got %h exp %h", i, rd_data, (i < 15) ? 8'(i + 1) : 8'h77);
      end
      cycle();
    end
    rd_ready = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 8'($urandom_range(0, 255));
      cycle();
    end
    wr_en = 0;
    n_tests++;
    if (count !== 5'd5) begin n_fail++; $display("FAIL async_pre_count: got %0d exp 5", count); end
    #2 rst = 1'b1;
    #1;
    n_tests += 2;
    if (count !== 5'd0) begin n_fail++; $display("FAIL async_count: got %0d exp 0", count); end
    if (empty !== 1'b1) begin n_fail++; $display("FAIL async_empty: got %b exp 1", empty); end
    #1 rst = 1'b0;
    exp_q.delete(); m_ovr = 0; m_drop = 0;
    @(negedge clk);
    wr_en = 1; wr_data = 8'h3C;
    cycle();
    wr_en = 0;
    n_tests++;
    if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL async_readback: got %h exp 3c", rd_data); end
  endtask

  task automatic test_random();
    logic [7:0] exp_head;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      wr_en    = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 75 : 30));
      wr_data  = 8'($urandom_range(0, 255));
      rd_ready = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 70));
      ovr_clr  = ($urandom_range(0, 99) < 5);
      cycle();
      exp_head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
      n_tests += 7;
      if (count !== 5'(exp_q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d exp %0d", c, count, exp_q.size()); end
      if (rd_data !== exp_head) begin n_fail++; $display("FAIL rand_rd_data[%0d]: got %h exp %h", c, rd_data, exp_head); end
      if (rd_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rand_rd_valid[%0d]: got %b", c, rd_valid); end
      if (full !== (exp_q.size() == 16)) begin n_fail++; $display("FAIL rand_full[%0d]: got %b", c, full); end
      if (empty !== (exp_q.size() == 0)) begin n_fail++; $display("FAIL rand_empty[%0d]: got %b", c, empty); end
      if (almost_full !== (exp_q.size() >= 12)) begin n_fail++; $display("FAIL rand_almost_full[%0d]: got %b", c, almost_full); end
      if (overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun[%0d]: got %b exp %b", c, overrun, m_ovr); end
`ifdef UART_RX_FIFO_DROP_CNT_EN
      n_tests++;
      if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rand_drop_cnt[%0d]: got %0d exp %0d", c, drop_cnt, m_drop); end
`endif
    end
    wr_en = 0; rd_ready = 0; ovr_clr = 0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 0; rd_ready = 0; ovr_clr = 0; wr_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_order();
    test_overrun();
    test_full_simul();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
